manchester_tx_frame_arbiter: RTL and testbench

- Shares one Manchester serial transmitter among N_SRC AXI-stream byte sources.
- Per frame:
  - Arbitrates round-robin at frame boundaries.
  - Emits preamble, sync and source-ID header bytes.
  - Passes the granted source's payload through until tlast.
  - Enforces an inter-frame idle gap.
- Its m_axis port drives the serializer's 8-bit s_axis input directly.

---
 rtl/manchester_tx_frame_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_manchester_tx_frame_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_tx_frame_arbiter.sv
// Round-robin frame arbiter feeding one Manchester serializer: preamble, sync, ID header,
// payload pass-through, idle gap. Optional CRC-8 trailer via MANCHESTER_TX_ARB_CRC8_EN.
module manchester_tx_frame_arbiter #(
   parameter int unsigned N_SRC         = 4,
   parameter int unsigned PREAMBLE_LEN  = 4,
   parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
   parameter logic [7:0]  SYNC_BYTE     = 8'hD5,
   parameter int unsigned GAP_CYCLES    = 16
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [8*N_SRC-1:0] s_axis_tdata,
   input  logic [N_SRC-1:0]   s_axis_tvalid,
   input  logic [N_SRC-1:0]   s_axis_tlast,
   output logic [N_SRC-1:0]   s_axis_tready,
   output logic [7:0]         m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [2:0]         grant_id,
   output logic               busy,
   output logic               frame_done
);

`ifdef MANCHESTER_TX_ARB_CRC8_EN
   typedef enum logic [2:0] {StIdle, StPreamble, StSync, StId, StPayload, StCrc, StGap} state_e;
`else
   typedef enum logic [2:0] {StIdle, StPreamble, StSync, StId, StPayload, StGap} state_e;
`endif

   localparam logic [7:0] PreLast    = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0] GapLast    = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
   localparam logic [2:0] LastInit   = 3'(N_SRC - 1);
   localparam state_e     AfterFrame = (GAP_CYCLES == 0) ? StIdle : StGap;

   state_e     state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [2:0] last_grant_q, last_grant_d;
   logic [7:0] tdata_q, tdata_d;
   logic       tvalid_q, tvalid_d;
   logic [7:0] cnt_q, cnt_d;

   logic       arb_found;
   logic [2:0] arb_idx;
   int         arb_tgt;
   logic [7:0] sel_data;
   logic       sel_valid;
   logic       sel_last;
   logic       hdr_acc;
   logic       pay_acc;

`ifdef MANCHESTER_TX_ARB_CRC8_EN
   logic [7:0] crc_q, crc_d;

   // Poly 0x07, MSB first, no reflection, no final XOR.
   function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int b = 0; b < 8; b++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction
`endif

   // Search from last_grant+1 upward; the lowest offset with a request wins.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_tgt   = 0;
      for (int k = 0; k < int'(N_SRC); k++) begin
         arb_tgt = int'(last_grant_q) + 1 + k;
         if (arb_tgt >= int'(N_SRC)) arb_tgt = arb_tgt - int'(N_SRC);
         for (int j = 0; j < int'(N_SRC); j++) begin
            if (!arb_found && (j == arb_tgt) && s_axis_tvalid[j]) begin
               arb_found = 1'b1;
               arb_idx   = 3'(j);
            end
         end
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (grant_q == 3'(i)) begin
            sel_data  = s_axis_tdata[8*i +: 8];
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
         end
      end
   end

   assign hdr_acc = tvalid_q && m_axis_tready;
   assign pay_acc = sel_valid && m_axis_tready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      tdata_d      = tdata_q;
      tvalid_d     = tvalid_q;
      cnt_d        = cnt_q;
`ifdef MANCHESTER_TX_ARB_CRC8_EN
      crc_d        = crc_q;
`endif
      case (state_q)
         StIdle: begin
            if (arb_found) begin
               grant_d      = arb_idx;
               last_grant_d = arb_idx;
               tdata_d      = PREAMBLE_BYTE;
               tvalid_d     = 1'b1;
               cnt_d        = '0;
               state_d      = StPreamble;
            end
         end
         StPreamble: begin
            if (hdr_acc) begin
               if (cnt_q == PreLast) begin
                  tdata_d = SYNC_BYTE;
                  state_d = StSync;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StSync: begin
            if (hdr_acc) begin
               tdata_d = {5'b0, grant_q};
               state_d = StId;
            end
         end
         StId: begin
            if (hdr_acc) begin
               tvalid_d = 1'b0;
               state_d  = StPayload;
`ifdef MANCHESTER_TX_ARB_CRC8_EN
               crc_d    = crc8(8'h00, tdata_q);
`endif
            end
         end
         StPayload: begin
            if (pay_acc) begin
`ifdef MANCHESTER_TX_ARB_CRC8_EN
               crc_d = crc8(crc_q, sel_data);
               if (sel_last) begin
                  tdata_d  = crc8(crc_q, sel_data);
                  tvalid_d = 1'b1;
                  state_d  = StCrc;
               end
`else
               if (sel_last) begin
                  cnt_d   = '0;
                  state_d = AfterFrame;
               end
`endif
            end
         end
`ifdef MANCHESTER_TX_ARB_CRC8_EN
         StCrc: begin
            if (hdr_acc) begin
               tvalid_d = 1'b0;
               cnt_d    = '0;
               state_d  = AfterFrame;
            end
         end
`endif
         StGap: begin
            if (cnt_q == GapLast) state_d = StIdle;
            else                  cnt_d   = cnt_q + 8'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= LastInit;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         cnt_q        <= '0;
`ifdef MANCHESTER_TX_ARB_CRC8_EN
         crc_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tdata_q      <= tdata_d;
         tvalid_q     <= tvalid_d;
         cnt_q        <= cnt_d;
`ifdef MANCHESTER_TX_ARB_CRC8_EN
         crc_q        <= crc_d;
`endif
      end
   end

   // Payload is a zero-latency pass-through; header/trailer beats come from registers.
   always_comb begin
      s_axis_tready = '0;
      if (state_q == StPayload) begin
         m_axis_tdata  = sel_data;
         m_axis_tvalid = sel_valid;
         for (int i = 0; i < int'(N_SRC); i++) begin
            s_axis_tready[i] = (grant_q == 3'(i)) && m_axis_tready;
         end
      end else begin
         m_axis_tdata  = tdata_q;
         m_axis_tvalid = tvalid_q;
      end
   end

`ifdef MANCHESTER_TX_ARB_CRC8_EN
   assign frame_done = (state_q == StCrc) && hdr_acc;
`else
   assign frame_done = (state_q == StPayload) && pay_acc && sel_last;
`endif

   assign grant_id = grant_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_manchester_tx_frame_arbiter.sv
// Directed bench for manchester_tx_frame_arbiter (PREAMBLE_LEN=2, GAP_CYCLES=4, N_SRC=4).
module tb_manchester_tx_frame_arbiter;

   typedef logic [7:0] bq_t [$];

   logic        aclk;
   logic        aresetn;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tvalid;
   logic [3:0]  s_axis_tlast;
   logic [3:0]  s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [2:0]  grant_id;
   logic        busy;
   logic        frame_done;

   manchester_tx_frame_arbiter #(
      .N_SRC        (4),
      .PREAMBLE_LEN (2),
      .PREAMBLE_BYTE(8'h55),
      .SYNC_BYTE    (8'hD5),
      .GAP_CYCLES   (4)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .grant_id     (grant_id),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Per-source byte queues, {tlast, tdata}.
   logic [8:0] src_q [4][$];
   bq_t        out_q;
   logic [2:0] grant_log [$];
   int         done_cnt, done_pos;
   int         stall_at [4];
   int         stall_left [4];
   int         acc_cnt [4];
   logic [3:0] stalled;
   logic [3:0] acc;
   int         stall_obs, stall_tv, stall_gr;
   int         hold_viol, rdy1_cnt;
   logic       hold_prev;
   logic [7:0] hold_data;
   logic [3:0] rdy_pat;
   logic [1:0] ph;
   int         n_checks, n_pass;
   int         gap_n, gap_v;
   bq_t        exp_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_seq(input string tag, input bq_t exp);
      check({tag, "_len"}, out_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < out_q.size(); i++) begin
         check($sformatf("%s[%0d]", tag, i), {24'h0, out_q[i]}, {24'h0, exp[i]});
      end
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      for (int c = 0; c < budget && done_cnt < n; c++) begin
         @(posedge aclk);
         #2;
      end
      check({tag, "_done"}, done_cnt, n);
   endtask

   task automatic reset_dut();
      @(posedge aclk);
      #2;
      aresetn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         src_q[i].delete();
         stall_at[i]   = 0;
         stall_left[i] = 0;
         acc_cnt[i]    = 0;
      end
      repeat (2) @(posedge aclk);
      #2;
      aresetn = 1'b1;
      out_q.delete();
      grant_log.delete();
      done_cnt  = 0;
      done_pos  = 0;
      rdy1_cnt  = 0;
      hold_viol = 0;
      stall_obs = 0;
      stall_tv  = 0;
      stall_gr  = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      aresetn  = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      stalled   = '0;
      rdy_pat   = 4'b1111;
      ph        = '0;
      hold_prev = 1'b0;
      hold_data = '0;
      done_cnt  = 0;
      for (int i = 0; i < 4; i++) begin
         stall_at[i]   = 0;
         stall_left[i] = 0;
         acc_cnt[i]    = 0;
      end

      // Sources and sink: sample at negedge, drive 1 time unit after posedge.
      fork
         forever begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
               out_q.push_back(m_axis_tdata);
               if (frame_done) begin
                  done_cnt++;
                  done_pos = out_q.size();
                  grant_log.push_back(grant_id);
               end
            end
            if (hold_prev && (!m_axis_tvalid || m_axis_tdata != hold_data)) hold_viol++;
            hold_prev = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            if (s_axis_tready[1]) rdy1_cnt++;
            if (stalled[2]) begin
               stall_obs++;
               if (m_axis_tvalid) stall_tv++;
               if (!busy || grant_id != 3'd2) stall_gr++;
            end
            acc = s_axis_tvalid & s_axis_tready;
            @(posedge aclk);
            #1;
            m_axis_tready = rdy_pat[ph];
            ph = ph + 2'd1;
            for (int i = 0; i < 4; i++) begin
               if (acc[i] && src_q[i].size() > 0) begin
                  void'(src_q[i].pop_front());
                  acc_cnt[i]++;
                  if (acc_cnt[i] == stall_at[i]) stall_left[i] = 5;
               end
               if (stall_left[i] > 0) begin
                  stalled[i] = 1'b1;
                  stall_left[i]--;
                  s_axis_tvalid[i] = 1'b0;
               end else begin
                  stalled[i] = 1'b0;
                  if (src_q[i].size() > 0) begin
                     s_axis_tvalid[i]        = 1'b1;
                     s_axis_tdata[8*i +: 8]  = src_q[i][0][7:0];
                     s_axis_tlast[i]         = src_q[i][0][8];
                  end else begin
                     s_axis_tvalid[i] = 1'b0;
                     s_axis_tlast[i]  = 1'b0;
                  end
               end
            end
         end
      join_none

      // Reset values
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tready", s_axis_tready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_grant", grant_id, 0);

      // Frame ordering and gap
      reset_dut();
      src_q[0] = '{9'h0A1, 9'h0A2, 9'h1A3};
      wait_done("t1", 1, 100);
      gap_n = 0;
      gap_v = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge aclk);
         if (!busy) break;
         gap_n++;
         if (m_axis_tvalid) gap_v++;
      end
      check("t1_gap_cycles", gap_n, 4);
      check("t1_gap_tvalid", gap_v, 0);
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h00, 8'hA1, 8'hA2, 8'hA3};
      check_seq("t1", exp_q);
      check("t1_done_pos", done_pos, 7);
      check("t1_grant", grant_id, 0);

      // Round robin between sources 0 and 2
      reset_dut();
      src_q[0] = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3};
      src_q[2] = '{9'h0C0, 9'h1C1, 9'h0C2, 9'h1C3};
      wait_done("rr", 4, 400);
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h00, 8'hB0, 8'hB1,
                8'h55, 8'h55, 8'hD5, 8'h02, 8'hC0, 8'hC1,
                8'h55, 8'h55, 8'hD5, 8'h00, 8'hB2, 8'hB3,
                8'h55, 8'h55, 8'hD5, 8'h02, 8'hC2, 8'hC3};
      check_seq("rr", exp_q);
      check("rr_g0", grant_log[0], 0);
      check("rr_g1", grant_log[1], 2);
      check("rr_g2", grant_log[2], 0);
      check("rr_g3", grant_log[3], 2);
      check("rr_src1_ready", rdy1_cnt, 0);

      // Backpressure 1,0,0,1
      reset_dut();
      rdy_pat = 4'b1001;
      src_q[1] = '{9'h0D0, 9'h0D1, 9'h1D2};
      wait_done("bp", 1, 200);
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'hD0, 8'hD1, 8'hD2};
      check_seq("bp", exp_q);
      check("bp_hold", hold_viol, 0);
      rdy_pat = 4'b1111;

      // Stall of the granted source, competing request from source 0
      reset_dut();
      stall_at[2] = 2;
      src_q[2] = '{9'h0E0, 9'h0E1, 9'h0E2, 9'h1E3};
      for (int c = 0; c < 20 && !busy; c++) begin
         @(posedge aclk);
         #2;
      end
      check("st_busy", busy, 1);
      src_q[0] = '{9'h1F0};
      wait_done("st", 2, 300);
      check("st_obs", stall_obs, 5);
      check("st_tvalid", stall_tv, 0);
      check("st_grant_hold", stall_gr, 0);
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h02, 8'hE0, 8'hE1, 8'hE2, 8'hE3,
                8'h55, 8'h55, 8'hD5, 8'h00, 8'hF0};
      check_seq("st", exp_q);
      check("st_g0", grant_log[0], 2);
      check("st_g1", grant_log[1], 0);

      // Reset during the second payload beat of a source-3 frame
      reset_dut();
      src_q[3] = '{9'h030, 9'h031, 9'h032, 9'h133};
      for (int c = 0; c < 100 && out_q.size() < 5; c++) begin
         @(posedge aclk);
         #2;
      end
      check("mr_reach", out_q.size(), 5);
      aresetn = 1'b0;
      src_q[3].delete();
      @(posedge aclk);
      #2;
      aresetn = 1'b1;
      @(negedge aclk);
      check("mr_tvalid", m_axis_tvalid, 0);
      check("mr_tready", s_axis_tready, 0);
      check("mr_busy", busy, 0);
      check("mr_done", frame_done, 0);
      check("mr_tdata", m_axis_tdata, 0);
      check("mr_grant", grant_id, 0);
      check("mr_no_done", done_cnt, 0);
      @(posedge aclk);
      #2;
      out_q.delete();
      src_q[3] = '{9'h040, 9'h141};
      wait_done("mr", 1, 100);
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h03, 8'h40, 8'h41};
      check_seq("mr", exp_q);

      // Single-beat frame (CRC trailer when compiled in)
      reset_dut();
      src_q[0] = '{9'h101};
      wait_done("sb", 1, 100);
`ifdef MANCHESTER_TX_ARB_CRC8_EN
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h00, 8'h01, 8'h07};
      check_seq("crc", exp_q);
      check("crc_done_pos", done_pos, 6);
`else
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h00, 8'h01};
      check_seq("sb", exp_q);
      check("sb_done_pos", done_pos, 5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
